axis_packet_gen: RTL and testbench

//   Packet-oriented AXI4-Stream test source feeding the DMA S2MM slave port (S_AXIS_S2MM_0) of the system block.

---
 rtl/axis_gen_pkg.sv | 27 ++
 rtl/axis_gen_lfsr.sv | 24 ++
 rtl/axis_packet_gen.sv | 174 +++++++++++++++++
 tb/tb_axis_packet_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gen_pkg.sv
// Purpose : shared types and constants for the AXI4-Stream packet generator.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
// Contents: state_t, mode_t, LFSR_TAPS, HDR_MAGIC, lfsr_next().
package axis_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_COUNT = 1'b0,
    MODE_LFSR  = 1'b1
  } mode_t;

  // x^32 + x^22 + x^2 + x + 1 as a Fibonacci tap mask (stages 32,22,2,1 -> bits 31,21,1,0)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

  // One Fibonacci step: shift toward the MSB, feedback parity enters at bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_gen_lfsr.sv
// Purpose : 32-bit Fibonacci LFSR payload source with seed load and step.
// Latency : q updates one clock after load/step; load has priority over step.
// Backpr. : none internally; the caller asserts step only on an accepted word.
// Ports   : clk, load (reload SEED), step (advance one state), q (current state).
module axis_gen_lfsr
  import axis_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (load) begin
      q <= SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/axis_packet_gen.sv
// Purpose : packet-oriented AXI4-Stream test source (count or LFSR payload, programmable length/gap).
// Latency : first word valid one clock after enable is seen in IDLE; back-to-back packets have no bubble.
// Backpr. : words advance only on tvalid & tready; tvalid/tdata/tlast are held while stalled.
// Ports   : axi_aclk, axi_aresetn (sync, active low), enable, mode, pkt_len, gap_len,
//           m_axis_tdata/tkeep/tlast/tvalid/tready, pkt_count, busy.
// Option  : define AXIS_GEN_HDR_EN to prefix every packet with {16'hA5A5, pkt_count[15:0]}.
module axis_packet_gen
  import axis_gen_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          LEN_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'h1
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic [LEN_W-1:0]      gap_len,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           pkt_count,
  output logic                  busy
);

`ifdef AXIS_GEN_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  state_t           state;
  mode_t            lat_mode;
  logic [LEN_W-1:0] lat_len;
  logic [LEN_W-1:0] lat_gap;
  logic [LEN_W-1:0] word_idx;
  logic [LEN_W-1:0] gap_cnt;
  logic [31:0]      cnt;
  logic [31:0]      lfsr_q;
  logic             hdr_phase;

  logic             hs;
  logic             last_hs;
  logic             adv;
  logic             start;
  logic [LEN_W-1:0] new_len;
  mode_t            sel_mode;
  logic             load_pl;
  logic             step_lfsr;
  logic [31:0]      pl_word;
  logic [31:0]      pkt_count_nxt;
  logic [31:0]      hdr_word;

  // tvalid is only ever high in SEND, so a handshake implies SEND.
  assign hs      = m_axis_tvalid & m_axis_tready;
  assign last_hs = hs & m_axis_tlast;
  assign adv     = hs & ~m_axis_tlast;
  assign new_len = (pkt_len == '0) ? LEN_W'(1) : pkt_len;

  // start: a new packet's first word is loaded into the output register at this edge.
  always_comb begin
    start = 1'b0;
    case (state)
      IDLE:    start = enable;
      SEND:    start = last_hs & enable & (lat_gap == '0);
      GAP:     start = enable & (gap_cnt == lat_gap - LEN_W'(1));
      default: start = 1'b0;
    endcase
  end

  // The payload generators hold the value of the next word to be loaded; the one selected
  // by the active mode steps whenever a payload word is loaded, which happens exactly once
  // per payload handshake (preloading keeps tdata a plain register).
  assign sel_mode      = start ? mode_t'(mode) : lat_mode;
  assign load_pl       = adv | (start & ~HDR_EN);
  assign pl_word       = (sel_mode == MODE_LFSR) ? lfsr_q : cnt;
  assign step_lfsr     = load_pl & (sel_mode == MODE_LFSR);
  assign pkt_count_nxt = pkt_count + 32'(last_hs);
  // A back-to-back header must carry the count that includes the packet just finished.
  assign hdr_word      = {HDR_MAGIC, pkt_count_nxt[15:0]};

  assign m_axis_tkeep  = '1;

  axis_gen_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (axi_aclk),
    .load (~axi_aresetn),
    .step (step_lfsr),
    .q    (lfsr_q)
  );

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      busy          <= 1'b0;
      pkt_count     <= '0;
      cnt           <= '0;
      word_idx      <= '0;
      gap_cnt       <= '0;
      lat_len       <= LEN_W'(1);
      lat_gap       <= '0;
      lat_mode      <= MODE_COUNT;
      hdr_phase     <= 1'b0;
    end else begin
      pkt_count <= pkt_count_nxt;
      if (load_pl && sel_mode == MODE_COUNT) begin
        cnt <= cnt + 32'd1;
      end

      if (start) begin
        state         <= SEND;
        busy          <= 1'b1;
        m_axis_tvalid <= 1'b1;
        lat_len       <= new_len;
        lat_gap       <= gap_len;
        lat_mode      <= mode_t'(mode);
        word_idx      <= '0;
        if (HDR_EN) begin
          m_axis_tdata <= DATA_W'(hdr_word);
          m_axis_tlast <= 1'b0;
          hdr_phase    <= 1'b1;
        end else begin
          m_axis_tdata <= DATA_W'(pl_word);
          m_axis_tlast <= (new_len == LEN_W'(1));
          hdr_phase    <= 1'b0;
        end
      end else begin
        case (state)
          SEND: begin
            if (adv) begin
              m_axis_tdata <= DATA_W'(pl_word);
              hdr_phase    <= 1'b0;
              if (hdr_phase) begin
                word_idx     <= '0;
                m_axis_tlast <= (lat_len == LEN_W'(1));
              end else begin
                word_idx     <= word_idx + LEN_W'(1);
                m_axis_tlast <= (word_idx + LEN_W'(1) == lat_len - LEN_W'(1));
              end
            end else if (last_hs) begin
              // Packet done and no immediate restart: gap if still enabled, else stop.
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              gap_cnt       <= '0;
              if (enable) begin
                state <= GAP;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + LEN_W'(1);
            if (gap_cnt == lat_gap - LEN_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_gen.sv
// Purpose : self-checking bench for axis_packet_gen with a queue-based scoreboard.
// Latency : n/a.
// Backpr. : tready is held high or randomised per phase.
module tb_axis_packet_gen;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        mode_i;
  logic [15:0] pkt_len;
  logic [15:0] gap_len;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic [31:0] pkt_count;
  logic        busy;

  always #5 clk = ~clk;

  axis_packet_gen dut (
    .axi_aclk      (clk),
    .axi_aresetn   (aresetn),
    .enable        (enable),
    .mode          (mode_i),
    .pkt_len       (pkt_len),
    .gap_len       (gap_len),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .pkt_count     (pkt_count),
    .busy          (busy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];     // {tlast, tdata}
  int          exp_gap[$];   // idle cycles expected before each non-first packet of a phase
  logic [31:0] m_cnt;
  logic [31:0] m_lfsr;
  logic [31:0] exp_pkts;
  int          phase_id = 0;
  int          starts = 0;
  int          beats = 0;
  int          pkt_beats = 0;
  bit          rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference LFSR: polynomial x^32+x^22+x^2+x+1, new bit from stages 32,22,2,1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  task automatic model_reset();
    m_cnt    = 32'd0;
    m_lfsr   = 32'd1;
    exp_pkts = 32'd0;
    exp_q.delete();
    exp_gap.delete();
  endtask

  task automatic push_pkt(input int len, input int md);
    int l;
    logic [31:0] v;
    l = (len == 0) ? 1 : len;
`ifdef AXIS_GEN_HDR_EN
    exp_q.push_back({1'b0, 16'hA5A5, exp_pkts[15:0]});
`endif
    for (int i = 0; i < l; i++) begin
      if (md != 0) begin
        v = m_lfsr;
        m_lfsr = lfsr_step(m_lfsr);
      end else begin
        v = m_cnt;
        m_cnt = m_cnt + 32'd1;
      end
      exp_q.push_back({(i == l - 1), v});
    end
    exp_pkts = exp_pkts + 32'd1;
  endtask

  // One phase: fixed config, npk packets; enable drops once the last packet is on the wire
  // (and drop_at of its beats accepted), then config is scrambled to show it is not re-latched.
  task automatic run_phase(input int len, input int gap, input int md, input int npk,
                           input bit rr, input int drop_at);
    int base;
    int cyc;
    phase_id++;
    pkt_len   = 16'(len);
    gap_len   = 16'(gap);
    mode_i    = md[0];
    rnd_ready = rr;
    for (int k = 0; k < npk; k++) begin
      push_pkt(len, md);
      if (k > 0) exp_gap.push_back(gap);
    end
    base   = starts;
    enable = 1'b1;
    cyc    = 0;
    while (!(starts >= base + npk && pkt_beats >= drop_at) && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("phase_start_timeout", 64'(cyc < 3000), 64'd1);
    enable  = 1'b0;
    pkt_len = 16'($urandom_range(0, 20));
    gap_len = 16'($urandom_range(0, 5));
    mode_i  = 1'($urandom_range(0, 1));
    cyc     = 0;
    while (!(busy == 1'b0 && tvalid == 1'b0 && exp_q.size() == 0) && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("phase_drain_timeout", 64'(cyc < 3000), 64'd1);
    chk("pkt_count", 64'(pkt_count), 64'(exp_pkts));
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    int b0;
    aresetn = 1'b0;
    enable  = 1'b0;
    mode_i  = 1'b0;
    pkt_len = '0;
    gap_len = '0;
    tready  = 1'b0;
    model_reset();

    fork
      // downstream ready
      forever begin
        @(posedge clk); #1;
        tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      // monitor / scoreboard
      begin
        bit          in_pkt = 1'b0;
        bit          stall_v = 1'b0;
        logic [31:0] stall_d = '0;
        logic        stall_l = 1'b0;
        int          idle = 0;
        int          last_end_phase = -1;
        logic [32:0] e;
        forever begin
          @(negedge clk);
          if (!aresetn) begin
            in_pkt = 1'b0;
            stall_v = 1'b0;
            last_end_phase = -1;
          end else begin
            if (stall_v) chk("stall_hold", {30'd0, tvalid, tlast, tdata}, {30'd0, 1'b1, stall_l, stall_d});
            stall_v = 1'b0;
            if (tvalid && !in_pkt) begin
              in_pkt = 1'b1;
              starts++;
              pkt_beats = 0;
              if (last_end_phase == phase_id) begin
                if (exp_gap.size() == 0) chk("gap_unexpected", 64'(idle), 64'hFFFF_FFFF);
                else chk("gap_cycles", 64'(idle), 64'(exp_gap.pop_front()));
              end
            end
            if (!tvalid) idle++;
            if (tvalid && tready) begin
              if (exp_q.size() == 0) begin
                chk("unexpected_beat", {31'd0, tlast, tdata}, 64'h1_FFFF_FFFF_FFFF);
              end else begin
                e = exp_q.pop_front();
                chk("beat", {31'd0, tlast, tdata}, {31'd0, e});
              end
              beats++;
              pkt_beats++;
              if (tlast) begin
                in_pkt = 1'b0;
                last_end_phase = phase_id;
                idle = 0;
              end
            end else if (tvalid) begin
              stall_v = 1'b1;
              stall_d = tdata;
              stall_l = tlast;
            end
          end
        end
      end
      begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_tkeep", 64'(tkeep), 64'hF);
    aresetn = 1'b1;

    run_phase(16, 0, 0, 2, 1'b0, 0);   // back-to-back count packets, 0..31
    run_phase(4, 3, 0, 3, 1'b1, 0);    // gaps under random backpressure
    run_phase(0, 0, 0, 4, 1'b1, 0);    // zero length -> single-word packets
    run_phase(0, 2, 0, 3, 1'b0, 0);
    run_phase(8, 2, 0, 1, 1'b0, 3);    // enable dropped mid-packet, packet still completes
    run_phase(6, 0, 1, 2, 1'b1, 0);    // LFSR payload
    run_phase(3, 1, 0, 2, 1'b0, 0);    // count continues where it stopped

    // reset mid-packet: tvalid low on the next cycle, LFSR restarts from the seed
    phase_id++;
    pkt_len   = 16'd20;
    gap_len   = 16'd0;
    mode_i    = 1'b1;
    rnd_ready = 1'b1;
    push_pkt(20, 1);
    b0     = beats;
    enable = 1'b1;
    cyc    = 0;
    while (beats < b0 + 5 && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("midrst_timeout", 64'(cyc < 3000), 64'd1);
    aresetn = 1'b0;
    enable  = 1'b0;
    @(negedge clk); #1;
    chk("midrst_tvalid", 64'(tvalid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
    chk("midrst_tdata", 64'(tdata), 64'd0);
    model_reset();
    phase_id++;
    aresetn = 1'b1;
    run_phase(5, 2, 1, 2, 1'b0, 0);
    run_phase(4, 0, 0, 2, 1'b1, 0);

    // randomised phases
    for (int r = 0; r < 12; r++) begin
      run_phase($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(1, 3), 1'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
